// File: rtl/seq_mult_shift_add.sv
// Sequential unsigned N x N multiplier: one shift-add step per clock through a ripple-carry adder.
// Result appears N+1 edges after start (counting the start edge); start is ignored while not idle.

module rca_Nbit #(
  parameter int N = 32
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign cout = c[N];

endmodule

module seq_mult_shift_add #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [N-1:0]  m;
  logic [N-1:0]  q;
  logic [N-1:0]  acc;
  logic [CW-1:0] count;

  logic [N-1:0]   addend;
  logic [N-1:0]   sum;
  logic           carry;
  logic [2*N-1:0] shifted;

  assign addend = q[0] ? m : '0;

  rca_Nbit #(.N(N)) u_rca (
    .x    (acc),
    .y    (addend),
    .cin  (1'b0),
    .s    (sum),
    .cout (carry)
  );

  // {c,S,Q} >> 1 over 2N+1 bits; the shifted-in MSB is always 0, so only the low 2N bits are kept.
  assign shifted = {carry, sum, q[N-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      p     <= '0;
      m     <= '0;
      q     <= '0;
      acc   <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m     <= a;
            q     <= b;
            acc   <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= shifted[2*N-1:N];
          q     <= shifted[N-1:0];
          count <= count + 1'b1;
          if (count == CW'(N-1)) begin
            p     <= shifted;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Bench for seq_mult_shift_add: an N=8 instance for directed scenarios, an N=32 instance for a random sweep.
module tb_seq_mult_shift_add;

  logic        clk;
  logic        rst_n;

  logic        start8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] p8;

  logic        start32;
  logic [31:0] a32, b32;
  logic        busy32, done32;
  logic [63:0] p32;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] q8[$];
  logic [63:0] q32[$];

  seq_mult_shift_add #(.N(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .p     (p8)
  );

  seq_mult_shift_add #(.N(32)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start32),
    .a     (a32),
    .b     (b32),
    .busy  (busy32),
    .done  (done32),
    .p     (p32)
  );

  always #5 clk = ~clk;

  // Stimulus only: launches one N=8 multiply, optionally re-asserts start with new operands at RUN cycle inj.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input int inj,
                      output int edges, output int bcyc, output logic got_done);
    logic [15:0] e;
    @(negedge clk);
    a8 = av; b8 = bv; start8 = 1'b1;
    e = {8'b0, av} * {8'b0, bv};
    q8.push_back(e);
    edges = 0; bcyc = 0; got_done = 1'b0;
    while (edges < 40 && !got_done) begin
      @(negedge clk);
      edges++;
      if (edges == 1) begin
        start8 = 1'b0;
        a8 = ~av; b8 = ~bv;
      end
      if (inj != 0 && edges == inj) begin
        start8 = 1'b1; a8 = 8'd100; b8 = 8'd100;
      end
      if (inj != 0 && edges == inj + 1) start8 = 1'b0;
      if (busy8) bcyc++;
      if (done8) got_done = 1'b1;
    end
  endtask

  task automatic test_reset;
    logic [15:0] exp;
    int k;
    rst_n = 1'b0;
    start8 = 1'b1; a8 = 8'd3; b8 = 8'd5;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy8, done8, p8} !== 18'd0) $display("FAIL reset_state: busy=%b done=%b p=%h required 0/0/0000", busy8, done8, p8);
    else n_pass++;
    rst_n = 1'b1;
    q8.push_back(16'd15);
    @(negedge clk);
    start8 = 1'b0;
    n_checks++;
    if (busy8 !== 1'b1) $display("FAIL start_after_reset: busy=%b required 1", busy8);
    else n_pass++;
    k = 0;
    while (!done8 && k < 40) begin @(negedge clk); k++; end
    exp = q8.pop_front();
    n_checks++;
    if (!done8 || p8 !== exp) $display("FAIL reset_then_mult: done=%b p=%0d required p=%0d", done8, p8, exp);
    else n_pass++;
  endtask

  task automatic test_basic;
    int ed, bc;
    logic gd;
    logic [15:0] exp;
    run8(8'd3, 8'd5, 0, ed, bc, gd);
    exp = q8.pop_front();
    n_checks++;
    if (!gd || p8 !== exp) $display("FAIL basic_product: done=%b p=%0d required %0d", gd, p8, exp);
    else n_pass++;
    n_checks++;
    if (ed !== 9) $display("FAIL basic_done_edge: done on edge %0d required 9", ed);
    else n_pass++;
    n_checks++;
    if (bc !== 8) $display("FAIL basic_busy_cycles: busy %0d cycles required 8", bc);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done8 !== 1'b0 || p8 !== exp) $display("FAIL basic_pulse_hold: done=%b p=%0d required done=0 p=%0d", done8, p8, exp);
    else n_pass++;
  endtask

  task automatic test_max;
    int ed, bc;
    logic gd;
    logic [15:0] exp;
    run8(8'd255, 8'd255, 0, ed, bc, gd);
    exp = q8.pop_front();
    n_checks++;
    if (!gd || p8 !== exp || p8 !== 16'hFE01) $display("FAIL max_product: p=%h required %h", p8, exp);
    else n_pass++;
  endtask

  task automatic test_zero;
    int ed, bc;
    logic gd;
    logic [15:0] exp;
    run8(8'd0, 8'd200, 0, ed, bc, gd);
    exp = q8.pop_front();
    n_checks++;
    if (!gd || p8 !== exp || ed !== 9) $display("FAIL zero_a: p=%0d edge=%0d required p=%0d edge=9", p8, ed, exp);
    else n_pass++;
    run8(8'd200, 8'd0, 0, ed, bc, gd);
    exp = q8.pop_front();
    n_checks++;
    if (!gd || p8 !== exp || ed !== 9 || bc !== 8) $display("FAIL zero_b: p=%0d edge=%0d busy=%0d required p=%0d edge=9 busy=8", p8, ed, bc, exp);
    else n_pass++;
  endtask

  task automatic test_start_while_busy;
    int ed, bc, extra;
    logic gd;
    logic [15:0] exp;
    run8(8'd7, 8'd9, 3, ed, bc, gd);
    exp = q8.pop_front();
    n_checks++;
    if (!gd || p8 !== exp || ed !== 9) $display("FAIL busy_start_product: p=%0d edge=%0d required p=%0d edge=9", p8, ed, exp);
    else n_pass++;
    extra = 0;
    repeat (14) begin
      @(negedge clk);
      if (done8 || busy8) extra++;
    end
    n_checks++;
    if (extra !== 0) $display("FAIL busy_start_no_second: %0d extra busy/done cycles required 0", extra);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int ed, bc, k, spurious;
    logic gd;
    logic [15:0] exp, dropped;
    @(negedge clk);
    a8 = 8'd12; b8 = 8'd12; start8 = 1'b1;
    q8.push_back(16'd144);
    k = 0;
    while (k < 4) begin
      @(negedge clk);
      k++;
      start8 = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy8, done8, p8} !== 18'd0) $display("FAIL reset_mid_clear: busy=%b done=%b p=%h required 0/0/0000", busy8, done8, p8);
    else n_pass++;
    dropped = q8.pop_back();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    repeat (20) begin
      @(negedge clk);
      if (done8 || busy8) spurious++;
    end
    n_checks++;
    if (spurious !== 0 || p8 !== 16'd0) $display("FAIL reset_mid_no_done: activity=%0d p=%0d required 0/0 (dropped %0d)", spurious, p8, dropped);
    else n_pass++;
    run8(8'd12, 8'd12, 0, ed, bc, gd);
    exp = q8.pop_front();
    n_checks++;
    if (!gd || p8 !== exp) $display("FAIL reset_mid_restart: p=%0d required %0d", p8, exp);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int ed, bc;
    logic gd;
    logic [15:0] exp;
    run8(8'd5, 8'd6, 0, ed, bc, gd);
    exp = q8.pop_front();
    n_checks++;
    if (!gd || p8 !== exp) $display("FAIL b2b_first: p=%0d required %0d", p8, exp);
    else n_pass++;
    run8(8'd17, 8'd13, 0, ed, bc, gd);
    exp = q8.pop_front();
    n_checks++;
    if (!gd || p8 !== exp || ed !== 9 || bc !== 8) $display("FAIL b2b_second: p=%0d edge=%0d busy=%0d required p=%0d edge=9 busy=8", p8, ed, bc, exp);
    else n_pass++;
  endtask

  task automatic test_random32;
    logic [31:0] ra, rb;
    logic [63:0] exp;
    int k;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom();
      rb = $urandom();
      if (i == 0) begin ra = '1; rb = '1; end
      @(negedge clk);
      a32 = ra; b32 = rb; start32 = 1'b1;
      q32.push_back({32'b0, ra} * {32'b0, rb});
      @(negedge clk);
      start32 = 1'b0;
      a32 = $urandom(); b32 = $urandom();
      k = 0;
      while (!done32 && k < 80) begin @(negedge clk); k++; end
      exp = q32.pop_front();
      n_checks++;
      if (!done32 || p32 !== exp) $display("FAIL rand32[%0d]: a=%h b=%h p=%h required %h", i, ra, rb, p32, exp);
      else n_pass++;
    end
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start32 = 1'b0; a32 = '0; b32 = '0;
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_random32();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
